// File: rtl/perceptron_engine.sv
// perceptron_engine: serial-MAC perceptron node, y = sign(b + sum_i (x_i*w_i) >>> FRAC).
// One feature is accumulated per cycle; weights and bias are written through a register port.
module perceptron_engine #(
  parameter int N_IN  = 2,
  parameter int X_W   = 7,
  parameter int W_W   = 14,
  parameter int FRAC  = 4,
  parameter int ACC_W = 14,
  parameter int SAT   = 0,
  localparam int AW   = $clog2(N_IN + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                w_we_i,
  input  logic [AW-1:0]       w_addr_i,
  input  logic [ACC_W-1:0]    w_data_i,
  output logic                w_err_o,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [N_IN*X_W-1:0] in_x_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [ACC_W-1:0]    out_sum_o,
  output logic [1:0]          out_y_o
);
  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int PW = X_W + W_W;
  localparam int EW = ((PW > ACC_W) ? PW : ACC_W) + 1;
  localparam logic [AW-1:0]    BIAS_ADDR = AW'(N_IN);
  localparam logic [IW-1:0]    LAST_IDX  = IW'(N_IN - 1);
  localparam logic [ACC_W-1:0] ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MAC = 2'd1, S_DONE = 2'd2} state_t;
  state_t state_q, state_d;

  logic [IW-1:0]       idx_q, idx_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [N_IN*X_W-1:0] x_q, x_d;
  logic [W_W-1:0]      w_q [N_IN];
  logic [W_W-1:0]      w_d [N_IN];
  logic [ACC_W-1:0]    b_q, b_d;
  logic                ovr_vld_q, ovr_vld_d;
  logic [IW-1:0]       ovr_idx_q, ovr_idx_d;
  logic [W_W-1:0]      ovr_val_q, ovr_val_d;
  logic [ACC_W-1:0]    sum_q, sum_d;
  logic [1:0]          y_q, y_d;
  logic                err_q, err_d;

  logic                hs_s, wr_ok_s;
  logic [X_W-1:0]      x_cur_s;
  logic [W_W-1:0]      w_cur_s;
  logic signed [EW-1:0] xe_s, we_s, prod_s;
  logic [ACC_W-1:0]    term_s, acc_nxt_s;
  logic [ACC_W:0]      add_s;

  assign hs_s    = (state_q == S_IDLE) && in_valid_i;
  assign wr_ok_s = w_we_i && (state_q == S_IDLE) && (w_addr_i <= BIAS_ADDR);

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid_i) state_d = S_MAC; else state_d = S_IDLE;
      S_MAC:  if (idx_q == LAST_IDX) state_d = S_DONE; else state_d = S_MAC;
      S_DONE: if (out_ready_i) state_d = S_IDLE; else state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    case (state_q)
      S_IDLE:  begin in_ready_o = 1'b1; out_valid_o = 1'b0; end
      S_MAC:   begin in_ready_o = 1'b0; out_valid_o = 1'b0; end
      S_DONE:  begin in_ready_o = 1'b0; out_valid_o = 1'b1; end
      default: begin in_ready_o = 1'b0; out_valid_o = 1'b0; end
    endcase
  end

  assign out_sum_o = sum_q;
  assign out_y_o   = y_q;
  assign w_err_o   = err_q;

  // A weight written in the handshake cycle must not affect that vector, so its old value is kept aside.
  always_comb begin
    if (ovr_vld_q && (ovr_idx_q == idx_q)) w_cur_s = ovr_val_q;
    else                                   w_cur_s = w_q[idx_q];
    x_cur_s   = x_q[X_W-1:0];
    xe_s      = {{(EW-X_W){x_cur_s[X_W-1]}}, x_cur_s};
    we_s      = {{(EW-W_W){w_cur_s[W_W-1]}}, w_cur_s};
    prod_s    = xe_s * we_s;
    term_s    = ACC_W'(prod_s >>> FRAC);
    add_s     = {acc_q[ACC_W-1], acc_q} + {term_s[ACC_W-1], term_s};
    if ((SAT != 0) && (add_s[ACC_W] != add_s[ACC_W-1])) begin
      acc_nxt_s = add_s[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_nxt_s = add_s[ACC_W-1:0];
    end
  end

  // Datapath next-state: weight port, operand capture and the serial MAC step.
  always_comb begin
    idx_d     = idx_q;
    acc_d     = acc_q;
    x_d       = x_q;
    ovr_vld_d = ovr_vld_q;
    ovr_idx_d = ovr_idx_q;
    ovr_val_d = ovr_val_q;
    sum_d     = sum_q;
    y_d       = y_q;
    err_d     = w_we_i && !wr_ok_s;
    for (int i = 0; i < N_IN; i++) begin
      if (wr_ok_s && (w_addr_i == AW'(i))) w_d[i] = w_data_i[W_W-1:0];
      else                                 w_d[i] = w_q[i];
    end
    if (wr_ok_s && (w_addr_i == BIAS_ADDR)) b_d = w_data_i;
    else                                    b_d = b_q;
    case (state_q)
      S_IDLE: begin
        if (hs_s) begin
          x_d       = in_x_i;
          acc_d     = b_q;
          idx_d     = {IW{1'b0}};
          ovr_vld_d = wr_ok_s && (w_addr_i != BIAS_ADDR);
          ovr_idx_d = w_addr_i[IW-1:0];
          ovr_val_d = w_q[w_addr_i[IW-1:0]];
        end else begin
          acc_d = acc_q;
        end
      end
      S_MAC: begin
        x_d   = x_q >> X_W;
        acc_d = acc_nxt_s;
        idx_d = idx_q + IW'(1'b1);
        if (idx_q == LAST_IDX) begin
          sum_d = acc_nxt_s;
          y_d   = acc_nxt_s[ACC_W-1] ? 2'b11 : 2'b01;
        end else begin
          sum_d = sum_q;
        end
      end
      S_DONE:  acc_d = acc_q;
      default: acc_d = acc_q;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q     <= {IW{1'b0}};
      acc_q     <= {ACC_W{1'b0}};
      x_q       <= {(N_IN*X_W){1'b0}};
      b_q       <= {ACC_W{1'b0}};
      ovr_vld_q <= 1'b0;
      ovr_idx_q <= {IW{1'b0}};
      ovr_val_q <= {W_W{1'b0}};
      sum_q     <= {ACC_W{1'b0}};
      y_q       <= 2'b01;
      err_q     <= 1'b0;
      for (int i = 0; i < N_IN; i++) w_q[i] <= {W_W{1'b0}};
    end else begin
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      x_q       <= x_d;
      b_q       <= b_d;
      ovr_vld_q <= ovr_vld_d;
      ovr_idx_q <= ovr_idx_d;
      ovr_val_q <= ovr_val_d;
      sum_q     <= sum_d;
      y_q       <= y_d;
      err_q     <= err_d;
      for (int i = 0; i < N_IN; i++) w_q[i] <= w_d[i];
    end
  end
endmodule

// File: tb/tb_perceptron_engine.sv
// Bench for perceptron_engine: wrap/saturating 2-input builds share stimulus; a 4-input build runs random traffic.
module tb_perceptron_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        w_we, in_valid, out_ready;
  logic [1:0]  w_addr;
  logic [13:0] w_data, in_x;
  logic        w_err_a, in_ready_a, out_valid_a, w_err_b, in_ready_b, out_valid_b;
  logic [13:0] out_sum_a, out_sum_b;
  logic [1:0]  out_y_a, out_y_b;

  logic        w_we4, in_valid4, out_ready4, w_err4, in_ready4, out_valid4;
  logic [2:0]  w_addr4;
  logic [13:0] w_data4, out_sum4;
  logic [27:0] in_x4;
  logic [1:0]  out_y4;

  perceptron_engine #(.N_IN(2), .SAT(0)) dut_a (
    .clk_i(clk), .rst_i(rst), .w_we_i(w_we), .w_addr_i(w_addr), .w_data_i(w_data), .w_err_o(w_err_a),
    .in_valid_i(in_valid), .in_ready_o(in_ready_a), .in_x_i(in_x), .out_valid_o(out_valid_a),
    .out_ready_i(out_ready), .out_sum_o(out_sum_a), .out_y_o(out_y_a));
  perceptron_engine #(.N_IN(2), .SAT(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .w_we_i(w_we), .w_addr_i(w_addr), .w_data_i(w_data), .w_err_o(w_err_b),
    .in_valid_i(in_valid), .in_ready_o(in_ready_b), .in_x_i(in_x), .out_valid_o(out_valid_b),
    .out_ready_i(out_ready), .out_sum_o(out_sum_b), .out_y_o(out_y_b));
  perceptron_engine #(.N_IN(4), .SAT(0)) dut_4 (
    .clk_i(clk), .rst_i(rst), .w_we_i(w_we4), .w_addr_i(w_addr4), .w_data_i(w_data4), .w_err_o(w_err4),
    .in_valid_i(in_valid4), .in_ready_o(in_ready4), .in_x_i(in_x4), .out_valid_o(out_valid4),
    .out_ready_i(out_ready4), .out_sum_o(out_sum4), .out_y_o(out_y4));

  int total = 0;
  int bad = 0;
  int q_a[$];
  int q_b[$];
  int q_4[$];
  int mw[2];
  int mb;
  int mw4[4];
  int mb4;

  typedef struct {
    int w0; int w1; int b; int x0; int x1; int e_wrap; int e_sat;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  function automatic int t14(input longint v);
    logic [63:0] u;
    u = v;
    return int'($signed(u[13:0]));
  endfunction

  function automatic int model(input int n, input int x0, input int x1, input int x2, input int x3,
                               input int w0, input int w1, input int w2, input int w3,
                               input int b, input bit sat);
    int xs[4];
    int ws[4];
    longint acc, s;
    xs[0] = x0; xs[1] = x1; xs[2] = x2; xs[3] = x3;
    ws[0] = w0; ws[1] = w1; ws[2] = w2; ws[3] = w3;
    acc = b;
    for (int i = 0; i < n; i++) begin
      s = acc + longint'(t14((longint'(xs[i]) * longint'(ws[i])) >>> 4));
      if (sat) begin
        if (s > 8191) s = 8191;
        else if (s < -8192) s = -8192;
        acc = s;
      end else begin
        acc = t14(s);
      end
    end
    return int'(acc);
  endfunction

  task automatic wr2(input int addr, input int data);
    @(negedge clk);
    w_we = 1'b1; w_addr = 2'(addr); w_data = 14'(data);
    @(negedge clk);
    w_we = 1'b0;
    chk("werr_ok", int'(w_err_a), 0);
    if (addr < 2) mw[addr] = data;
    else mb = data;
  endtask

  task automatic push_model2(input int x0, input int x1);
    q_a.push_back(model(2, x0, x1, 0, 0, mw[0], mw[1], 0, 0, mb, 1'b0));
    q_b.push_back(model(2, x0, x1, 0, 0, mw[0], mw[1], 0, 0, mb, 1'b1));
  endtask

  // Drives one handshake; returns at the falling edge of the first MAC cycle with in_x scrambled.
  task automatic send2(input int x0, input int x1);
    @(negedge clk);
    chk("in_ready", int'(in_ready_a), 1);
    in_valid = 1'b1;
    in_x = {7'(x1), 7'(x0)};
    @(negedge clk);
    in_valid = 1'b0;
    in_x = 14'($urandom);
  endtask

  task automatic cmp2();
    int e, f;
    if (q_a.size() == 0 || q_b.size() == 0) begin
      fail_now("scoreboard_empty");
    end else begin
      e = q_a.pop_front();
      f = q_b.pop_front();
      chk("sum_wrap", int'($signed(out_sum_a)), e);
      chk("y_wrap", int'(out_y_a), (e < 0) ? 3 : 1);
      chk("valid_sat", int'(out_valid_b), 1);
      chk("sum_sat", int'($signed(out_sum_b)), f);
      chk("y_sat", int'(out_y_b), (f < 0) ? 3 : 1);
    end
  endtask

  task automatic get2();
    int lat;
    bit found;
    lat = 1;
    found = 1'b0;
    out_ready = 1'b1;
    while (!found && lat < 30) begin
      if (out_valid_a) begin
        found = 1'b1;
        chk("latency", lat, 3);
        cmp2();
      end else begin
        @(negedge clk);
        lat++;
      end
    end
    if (!found) fail_now("result_timeout");
  endtask

  initial begin
    rst = 1'b1;
    w_we = 1'b0; w_addr = 2'd0; w_data = 14'd0; in_valid = 1'b0; in_x = 14'd0; out_ready = 1'b1;
    w_we4 = 1'b0; w_addr4 = 3'd0; w_data4 = 14'd0; in_valid4 = 1'b0; in_x4 = 28'd0; out_ready4 = 1'b1;
    mw[0] = 0; mw[1] = 0; mb = 0;
    tbl[0] = '{16, 32, 0, 3, -2, -1, -1};
    tbl[1] = '{16, 32, 5, 3, -2, 4, 4};
    tbl[2] = '{16, 0, 8191, 1, 0, -8192, 8191};
    tbl[3] = '{16, 16, -8192, -1, -1, 8190, -8192};
    tbl[4] = '{-8192, 8191, 0, -64, 63, -516, -516};
    tbl[5] = '{100, -50, -3, 7, -9, 68, 68};
    tbl[6] = '{1, 1, 0, -1, 1, -1, -1};
    tbl[7] = '{2000, 2000, 8000, 63, 63, 7366, 8191};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready_a), 1);
    chk("rst_out_valid", int'(out_valid_a), 0);
    chk("rst_out_sum", int'(out_sum_a), 0);
    chk("rst_out_y", int'(out_y_a), 1);
    chk("rst_w_err", int'(w_err_a), 0);
    chk("rst_out_valid4", int'(out_valid4), 0);

    for (int i = 0; i < 8; i++) begin
      wr2(0, tbl[i].w0); wr2(1, tbl[i].w1); wr2(2, tbl[i].b);
      q_a.push_back(tbl[i].e_wrap);
      q_b.push_back(tbl[i].e_sat);
      send2(tbl[i].x0, tbl[i].x1);
      get2();
    end

    // Back-pressure with dropped writes in MAC and DONE.
    wr2(0, 16); wr2(1, 32); wr2(2, 0);
    out_ready = 1'b0;
    push_model2(3, -2);
    send2(3, -2);
    w_we = 1'b1; w_addr = 2'd1; w_data = 14'd7;
    @(negedge clk);
    w_we = 1'b0;
    chk("err_mac", int'(w_err_a), 1);
    @(negedge clk);
    chk("err_mac_end", int'(w_err_a), 0);
    chk("stall_first_valid", int'(out_valid_a), 1);
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin w_we = 1'b1; w_addr = 2'd0; w_data = 14'd99; end
      @(negedge clk);
      w_we = 1'b0;
      if (k == 3) chk("err_done", int'(w_err_a), 1);
      if (k == 4) chk("err_done_end", int'(w_err_a), 0);
      chk("stall_valid", int'(out_valid_a), 1);
      chk("stall_in_ready", int'(in_ready_a), 0);
      chk("stall_sum", int'($signed(out_sum_a)), q_a[0]);
      chk("stall_y", int'(out_y_a), (q_a[0] < 0) ? 3 : 1);
    end
    out_ready = 1'b1;
    cmp2();
    @(negedge clk);
    chk("valid_drop", int'(out_valid_a), 0);
    push_model2(3, -2);
    send2(3, -2);
    get2();

    // Write landing in the handshake cycle: this vector sees the old weight, the next the new one.
    @(negedge clk);
    in_valid = 1'b1; in_x = {7'(-2), 7'(3)};
    w_we = 1'b1; w_addr = 2'd1; w_data = 14'd0;
    push_model2(3, -2);
    mw[1] = 0;
    @(negedge clk);
    in_valid = 1'b0; w_we = 1'b0;
    chk("werr_hs", int'(w_err_a), 0);
    get2();
    push_model2(3, -2);
    send2(3, -2);
    get2();
    @(negedge clk);
    in_valid = 1'b1; in_x = {7'(-2), 7'(3)};
    w_we = 1'b1; w_addr = 2'd2; w_data = 14'd100;
    push_model2(3, -2);
    mb = 100;
    @(negedge clk);
    in_valid = 1'b0; w_we = 1'b0;
    get2();
    push_model2(3, -2);
    send2(3, -2);
    get2();

    // Out-of-range address is dropped even in IDLE.
    @(negedge clk);
    w_we = 1'b1; w_addr = 2'd3; w_data = 14'd555;
    @(negedge clk);
    w_we = 1'b0;
    chk("err_addr", int'(w_err_a), 1);
    @(negedge clk);
    chk("err_addr_end", int'(w_err_a), 0);
    push_model2(3, -2);
    send2(3, -2);
    get2();

    // Reset in the middle of MAC.
    send2(5, 5);
    rst = 1'b1;
    #1;
    chk("midrst_valid", int'(out_valid_a), 0);
    chk("midrst_sum", int'(out_sum_a), 0);
    q_a.delete(); q_b.delete();
    mw[0] = 0; mw[1] = 0; mb = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    q_a.push_back(0); q_b.push_back(0);
    send2(5, 5);
    get2();

    // Four-input build: random weights and back-to-back random vectors.
    for (int i = 0; i < 5; i++) begin
      int v;
      v = int'($urandom_range(0, 16383)) - 8192;
      @(negedge clk);
      w_we4 = 1'b1; w_addr4 = 3'(i); w_data4 = 14'(v);
      if (i < 4) mw4[i] = v;
      else mb4 = v;
    end
    @(negedge clk);
    w_we4 = 1'b0;
    fork
      begin
        int xs[4];
        int guard;
        for (int v = 0; v < 200; v++) begin
          guard = 0;
          @(negedge clk);
          while (!in_ready4 && guard < 50) begin
            @(negedge clk);
            guard++;
          end
          for (int j = 0; j < 4; j++) xs[j] = int'($urandom_range(0, 127)) - 64;
          in_x4 = {7'(xs[3]), 7'(xs[2]), 7'(xs[1]), 7'(xs[0])};
          in_valid4 = 1'b1;
          q_4.push_back(model(4, xs[0], xs[1], xs[2], xs[3], mw4[0], mw4[1], mw4[2], mw4[3], mb4, 1'b0));
        end
        @(negedge clk);
        in_valid4 = 1'b0;
      end
      begin
        int got, cyc, last, e;
        got = 0; cyc = 0; last = -1;
        while (got < 200 && cyc < 3000) begin
          @(negedge clk);
          cyc++;
          if (out_valid4) begin
            if (q_4.size() == 0) begin
              fail_now("scoreboard4_empty");
            end else begin
              e = q_4.pop_front();
              chk("sum4", int'($signed(out_sum4)), e);
              chk("y4", int'(out_y4), (e < 0) ? 3 : 1);
            end
            if (last >= 0) chk("period4", cyc - last, 6);
            last = cyc;
            got++;
          end
        end
        if (got < 200) chk("n4_results", got, 200);
      end
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
